spi_master_burst_sequencer: RTL and testbench

Upstream feeder for `SPI_FPGA_MASTER`. It buffers outgoing packets in a TX FIFO and launches one master transaction per packet. It tracks each transaction through the master's CS and ACTION_DONE signals, then pushes each received packet into an RX FIFO. The block turns the master's single-shot launch interface into a streaming valid/ready burst interface with backpressure and a stuck-transaction timeout.

---
 rtl/spi_master_burst_sequencer.sv | 151 +++++++++++++++
 tb/tb_spi_master_burst_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_burst_sequencer.sv
// Streaming valid/ready front end for SPI_FPGA_MASTER: TX FIFO -> one master
// transaction per packet -> RX FIFO, with RX space reservation and a stuck-transaction timeout.
module spi_master_burst_sequencer #(
    parameter int PACK_LENGTH    = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   IN_CLOCK,
    input  logic                   IN_RESET_N,
    input  logic [PACK_LENGTH-1:0] IN_TX_DATA,
    input  logic                   IN_TX_VALID,
    output logic                   OUT_TX_READY,
    output logic [PACK_LENGTH-1:0] OUT_RX_DATA,
    output logic                   OUT_RX_VALID,
    input  logic                   IN_RX_READY,
    output logic [PACK_LENGTH-1:0] OUT_MASTER_DATA,
    output logic                   OUT_MASTER_LAUNCH,
    input  logic                   IN_MASTER_CS,
    input  logic [PACK_LENGTH-1:0] IN_MASTER_RECEIVE_DATA,
    input  logic                   IN_MASTER_ACTION_DONE,
    input  logic                   IN_CLEAR_TIMEOUT,
    output logic                   OUT_BUSY,
    output logic                   OUT_TIMEOUT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ACTIVE,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    state_t state, state_nxt;

    logic [PACK_LENGTH-1:0] tx_mem [FIFO_DEPTH];
    logic [PACK_LENGTH-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]            tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic                   tx_full, tx_empty, tx_push, tx_pop;
    logic                   rx_full, rx_empty, rx_push, rx_pop;
    logic                   cs_q, done_q, cs_fall, done_rise;
    logic [TW-1:0]          timer;
    logic                   timer_clr, timer_expired, timeout_set, start_ok;

    assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) && (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) && (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);

    assign tx_push = IN_TX_VALID && !tx_full;
    assign rx_pop  = !rx_empty && IN_RX_READY;

    assign OUT_TX_READY = !tx_full;
    assign OUT_RX_VALID = !rx_empty;
    assign OUT_RX_DATA  = rx_empty ? '0 : rx_mem[rx_rd_ptr[AW-1:0]];

    assign cs_fall       = cs_q && !IN_MASTER_CS;
    assign done_rise     = !done_q && IN_MASTER_ACTION_DONE;
    assign timer_expired = (timer == TIMER_LAST);

    // Only one transaction is ever in flight and none is pending while IDLE,
    // so a free RX slot at launch time is exactly the space reservation.
    assign start_ok = !tx_empty && !rx_full && IN_MASTER_CS;

    // NOTE: FIFO storage has no reset; pointers define validity, and the RX head is masked to 0 when empty.
    always_ff @(posedge IN_CLOCK) begin
        if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= IN_TX_DATA;
        if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= IN_MASTER_RECEIVE_DATA;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            tx_wr_ptr       <= '0;
            tx_rd_ptr       <= '0;
            rx_wr_ptr       <= '0;
            rx_rd_ptr       <= '0;
            cs_q            <= 1'b1;
            done_q          <= 1'b0;
            timer           <= '0;
            OUT_MASTER_DATA <= '0;
            OUT_TIMEOUT     <= 1'b0;
            state           <= S_IDLE;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + (AW+1)'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + (AW+1)'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + (AW+1)'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + (AW+1)'(1);
            cs_q   <= IN_MASTER_CS;
            done_q <= IN_MASTER_ACTION_DONE;
            if (timer_clr)              timer <= '0;
            else if (timer != TIMER_MAX) timer <= timer + TW'(1);
            if (tx_pop) OUT_MASTER_DATA <= tx_mem[tx_rd_ptr[AW-1:0]];
            if (timeout_set)           OUT_TIMEOUT <= 1'b1;
            else if (IN_CLEAR_TIMEOUT) OUT_TIMEOUT <= 1'b0;
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        timer_clr   = 1'b0;
        timeout_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    tx_pop    = 1'b1;
                    timer_clr = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (cs_fall) begin
                    timer_clr = 1'b1;
                    state_nxt = S_ACTIVE;
                end else if (timer_expired) begin
                    timeout_set = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (done_rise) begin
                    state_nxt = S_CAPTURE;
                end else if (timer_expired) begin
                    timeout_set = 1'b1;
                    state_nxt   = S_RELEASE;
                end
            end
            S_CAPTURE: begin
                rx_push   = 1'b1;
                state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (IN_MASTER_CS && !IN_MASTER_ACTION_DONE) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Decoded from the async-reset state so launch drops the moment reset asserts.
    assign OUT_MASTER_LAUNCH = (state == S_LAUNCH);
    assign OUT_BUSY          = (state != S_IDLE);

endmodule

// File: tb/tb_spi_master_burst_sequencer.sv
// Bench for spi_master_burst_sequencer: behavioural SPI master plus queue-based scoreboard.
module tb_spi_master_burst_sequencer;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] master_data;
    logic         launch;
    logic         m_cs, m_done;
    logic [W-1:0] m_rcv;
    logic         clear_to;
    logic         busy;
    logic         timeout;

    // Master pins come from the behavioural model or from manual drive.
    logic         master_en = 1'b0;
    logic         model_cs = 1'b1, model_done = 1'b0;
    logic [W-1:0] model_rcv = '0;
    logic         man_cs = 1'b1, man_done = 1'b0;
    assign m_cs   = master_en ? model_cs   : man_cs;
    assign m_done = master_en ? model_done : man_done;
    assign m_rcv  = model_rcv;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           txn_count = 0;
    int           rx_pops   = 0;
    bit           master_active = 1'b0;
    bit           forced_en = 1'b0;
    logic [W-1:0] forced_val = '0;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] exp_rx_q[$];

    always #5 clk = ~clk;

    spi_master_burst_sequencer #(
        .PACK_LENGTH(W),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .IN_CLOCK(clk),
        .IN_RESET_N(rst_n),
        .IN_TX_DATA(tx_data),
        .IN_TX_VALID(tx_valid),
        .OUT_TX_READY(tx_ready),
        .OUT_RX_DATA(rx_data),
        .OUT_RX_VALID(rx_valid),
        .IN_RX_READY(rx_ready),
        .OUT_MASTER_DATA(master_data),
        .OUT_MASTER_LAUNCH(launch),
        .IN_MASTER_CS(m_cs),
        .IN_MASTER_RECEIVE_DATA(m_rcv),
        .IN_MASTER_ACTION_DONE(m_done),
        .IN_CLEAR_TIMEOUT(clear_to),
        .OUT_BUSY(busy),
        .OUT_TIMEOUT(timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural SPI master: accepts a launch, runs one CS-low burst, returns a slave byte.
    initial begin
        logic [W-1:0] slave;
        forever begin
            @(negedge clk);
            if (master_en && rst_n === 1'b1 && launch === 1'b1) begin
                master_active = 1'b1;
                txn_count++;
                check("master_has_expected_tx", 32'(tx_q.size() > 0), 1);
                if (tx_q.size() > 0) begin
                    check("master_data", master_data, tx_q[0]);
                    void'(tx_q.pop_front());
                end
                slave = forced_en ? forced_val : W'($urandom);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                model_cs = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                model_rcv  = slave;
                model_done = 1'b1;
                exp_rx_q.push_back(slave);
                repeat ($urandom_range(1, 2)) @(negedge clk);
                model_cs = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                model_done    = 1'b0;
                master_active = 1'b0;
            end
        end
    end

    // RX consumer: every pop must match the next slave byte in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rx_ready === 1'b1 && rx_valid === 1'b1) begin
                rx_pops++;
                check("rx_pop_expected", 32'(exp_rx_q.size() > 0), 1);
                if (exp_rx_q.size() > 0) begin
                    check("rx_data_order", rx_data, exp_rx_q[0]);
                    void'(exp_rx_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic tx_write(input logic [W-1:0] d, input bit track);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t == 500) check("tx_ready_wait", tx_ready, 1);
        if (track) tx_q.push_back(d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic set_rx_ready(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
        @(negedge clk);
    endtask

    task automatic wait_launch(input string tag);
        int t = 0;
        while (launch !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(tag, launch, 1);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        set_rx_ready(1'b1);
        while ((exp_rx_q.size() != 0 || tx_q.size() != 0 || busy !== 1'b0 || master_active) && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("drain_rx_left", exp_rx_q.size(), 0);
        check("drain_tx_left", tx_q.size(), 0);
        check("drain_rx_valid", rx_valid, 0);
        set_rx_ready(1'b0);
    endtask

    initial begin
        int base;
        int t;
        int cnt;
        rst_n    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        clear_to = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_master_data", master_data, 0);
        check("rst_launch", launch, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        master_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single packet 0xEA, slave answers 0x53
        forced_en  = 1'b1;
        forced_val = 8'h53;
        base = txn_count;
        tx_write(8'hEA, 1'b1);
        t = 0;
        while (rx_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("single_rx_valid", rx_valid, 1);
        check("single_rx_data", rx_data, 8'h53);
        t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("single_busy_idle", busy, 0);
        check("single_txn_count", txn_count - base, 1);
        drain(200);
        forced_en = 1'b0;

        // Four packets back to back, consumed in order
        set_rx_ready(1'b1);
        base = txn_count;
        for (int i = 1; i <= 4; i++) tx_write(W'(i), 1'b1);
        drain(400);
        check("b2b_txn_count", txn_count - base, 4);

        // RX backpressure: only DEPTH transactions may run, TX then fills and refuses
        base = txn_count;
        for (int i = 0; i < 6; i++) tx_write(W'($urandom), 1'b1);
        t = 0;
        while ((txn_count - base < DEPTH || busy !== 1'b0 || master_active) && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        check("bp_txn_count", txn_count - base, DEPTH);
        check("bp_busy_idle", busy, 0);
        check("bp_rx_valid", rx_valid, 1);
        check("bp_tx_ready_two_held", tx_ready, 1);
        for (int i = 0; i < 2; i++) tx_write(W'($urandom), 1'b1);
        check("bp_tx_full", tx_ready, 0);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("bp_full_txn_count", txn_count - base, DEPTH);
        drain(800);
        check("bp_total_txn", txn_count - base, 8);

        // LAUNCH timeout: master disconnected, CS stays high
        master_en = 1'b0;
        base = rx_pops;
        tx_write(8'h3C, 1'b0);
        wait_launch("to_launch_seen");
        cnt = 0;
        while (launch === 1'b1 && cnt < TO + 20) begin
            cnt++;
            @(negedge clk);
        end
        check("to_launch_cycles", cnt, TO);
        check("to_flag_set", timeout, 1);
        check("to_busy_idle", busy, 0);
        check("to_no_rx_push", rx_valid, 0);
        repeat (5) @(negedge clk);
        check("to_flag_sticky", timeout, 1);
        clear_to = 1'b1;
        @(negedge clk);
        clear_to = 1'b0;
        check("to_flag_cleared", timeout, 0);

        // ACTIVE timeout with clear held: set must win, FSM parks in RELEASE
        tx_write(8'h5A, 1'b0);
        wait_launch("act_launch_seen");
        man_cs   = 1'b0;
        clear_to = 1'b1;
        cnt = 0;
        while (timeout !== 1'b1 && cnt < TO + 20) begin
            @(negedge clk);
            cnt++;
        end
        clear_to = 1'b0;
        check("act_timeout_cycles", cnt, TO + 1);
        check("act_set_wins", timeout, 1);
        check("act_release_busy", busy, 1);
        check("act_no_rx_push", rx_valid, 0);
        man_cs = 1'b1;
        repeat (2) @(negedge clk);
        check("act_back_idle", busy, 0);
        clear_to = 1'b1;
        @(negedge clk);
        clear_to = 1'b0;
        check("act_flag_cleared", timeout, 0);

        // Reset during ACTIVE with one packet sitting in RX
        master_en = 1'b1;
        tx_write(8'h11, 1'b1);
        t = 0;
        while ((rx_valid !== 1'b1 || busy !== 1'b0 || master_active) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rst_pre_rx_valid", rx_valid, 1);
        master_en = 1'b0;
        tx_write(8'h22, 1'b0);
        wait_launch("rst_pre_launch");
        man_cs = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_active_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_launch", launch, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_tx_ready", tx_ready, 1);
        exp_rx_q.delete();
        tx_q.delete();
        man_cs = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        master_en = 1'b1;
        @(negedge clk);
        base = txn_count;
        tx_write(8'hA5, 1'b1);
        drain(200);
        check("post_rst_txn", txn_count - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
